// File: rtl/cpu_pkg.sv
// Shared CPU types: machine word, reset vector and the fetch-queue entry.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: circular buffer of {pc, instr} entries with push, pop, flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign push_ok = push & (cnt_q != CntW'(Depth));
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_ok) begin
        rd_q <= ptr_inc(rd_q);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response tracking,
// redirect flush with stale-response dropping. Optional counters under FETCH_PERF_EN.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t       RESET_PC = RESET_VECTOR,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FQ_DEPTH);

  word_t           pc_q, pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] fq_count;
  logic [CntW:0]   inflight;
  word_t           tag_q [FQ_DEPTH];
  logic [PtrW-1:0] tag_wr_q, tag_rd_q;

  logic         req_fire, rsp_legal, rsp_drop;
  logic         fq_push, fq_pop, fq_empty;
  fetch_entry_t fq_in, fq_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FQ_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credit covers both in-flight requests and queued entries, so the queue cannot overflow.
  assign inflight       = {1'b0, outst_q} + {1'b0, fq_count};
  assign imem_req_valid = rst & ~redirect_valid & (inflight < (CntW+1)'(FQ_DEPTH));
  assign imem_req_addr  = word_align(pc_q);
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_legal = imem_rsp_valid & (outst_q != '0);
  assign rsp_drop  = rsp_legal & (redirect_valid | (drop_q != '0));
  assign fq_push   = rsp_legal & ~rsp_drop;
  assign fq_in     = '{pc: tag_q[tag_rd_q], instr: imem_rsp_data};

  assign if_valid    = rst & ~fq_empty & ~redirect_valid;
  assign fq_pop      = if_valid & if_ready;
  assign if_instr    = if_valid ? fq_head.instr : '0;
  assign if_pc       = if_valid ? fq_head.pc : '0;
  assign if_pc_plus4 = if_valid ? fq_head.pc + 32'd4 : '0;

  always_comb begin
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;

    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end else if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end

    unique case ({req_fire, rsp_legal})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    // Everything still in flight becomes stale; a response landing this cycle is already dropped.
    if (redirect_valid) begin
      drop_d = rsp_legal ? outst_q - CntW'(1) : outst_q;
    end else if (rsp_legal && (drop_q != '0)) begin
      drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Request address ring, one slot per outstanding request, consumed in response order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (req_fire) begin
        tag_q[tag_wr_q] <= word_align(pc_q);
        tag_wr_q        <= ptr_inc(tag_wr_q);
      end
      if (rsp_legal) begin
        tag_rd_q <= ptr_inc(tag_rd_q);
      end
    end
  end

  fetch_fifo #(
    .Depth (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fq_push),
    .push_data (fq_in),
    .pop       (fq_pop),
    .flush     (redirect_valid),
    .head      (fq_head),
    .empty     (fq_empty),
    .count     (fq_count)
  );

`ifdef FETCH_PERF_EN
  word_t fetched_q, stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (fq_pop && (fetched_q != '1)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (if_valid && !if_ready && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`endif

  rsp_outstanding_a: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outst_q != '0));

endmodule
